// File: rtl/ps2_player_input_ctrl_pkg.sv
// Shared scancode map, key indices and state encodings for the PS/2 player input path.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ps2_input_pkg;

  // Prefix bytes of the set-2 protocol
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Red player: plain (non-extended) codes
  localparam logic [7:0] RED_UP    = 8'h1D;  // W
  localparam logic [7:0] RED_DOWN  = 8'h1B;  // S
  localparam logic [7:0] RED_LEFT  = 8'h1C;  // A
  localparam logic [7:0] RED_RIGHT = 8'h23;  // D
  localparam logic [7:0] RED_BOMB  = 8'h29;  // Space

  // Blue player: arrows are E0-extended, bomb (Enter) is plain
  localparam logic [7:0] BLU_UP    = 8'h75;
  localparam logic [7:0] BLU_DOWN  = 8'h72;
  localparam logic [7:0] BLU_LEFT  = 8'h6B;
  localparam logic [7:0] BLU_RIGHT = 8'h74;
  localparam logic [7:0] BLU_BOMB  = 8'h5A;

  // Bit positions inside each player's held vector
  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int BOMB  = 4;
  localparam int NKEYS = 5;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXT_BRK} dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // Map (player, code, extended) to a key index; keypad codes without E0 miss.
  function automatic key_hit_t key_lookup(input logic blue, input logic [7:0] code,
                                          input logic ext);
    key_hit_t k;
    k.hit = 1'b1;
    k.idx = 3'd0;
    if (!blue) begin
      if (ext) begin
        k.hit = 1'b0;
      end else begin
        case (code)
          RED_UP:    k.idx = 3'(UP);
          RED_DOWN:  k.idx = 3'(DOWN);
          RED_LEFT:  k.idx = 3'(LEFT);
          RED_RIGHT: k.idx = 3'(RIGHT);
          RED_BOMB:  k.idx = 3'(BOMB);
          default:   k.hit = 1'b0;
        endcase
      end
    end else begin
      if (ext) begin
        case (code)
          BLU_UP:    k.idx = 3'(UP);
          BLU_DOWN:  k.idx = 3'(DOWN);
          BLU_LEFT:  k.idx = 3'(LEFT);
          BLU_RIGHT: k.idx = 3'(RIGHT);
          default:   k.hit = 1'b0;
        endcase
      end else if (code == BLU_BOMB) begin
        k.idx = 3'(BOMB);
      end else begin
        k.hit = 1'b0;
      end
    end
    return k;
  endfunction

  // One-hot of the highest-priority held direction (up > down > left > right).
  function automatic logic [3:0] first_held(input logic [3:0] held);
    logic [3:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (held[i]) r = 4'b0001 << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_player_input_ctrl_if.sv
// Bundle of keyboard pins and decoded player/receiver outputs.
// Latency: n/a (wiring only).
// Backpressure: none; every output is a level or a single-cycle strobe.
interface ps2_player_input_ctrl_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [3:0] r_dir;
  logic       r_bomb;
  logic [3:0] b_dir;
  logic       b_bomb;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  // Keyboard / stimulus side
  modport master (
    output PS2_CLK, PS2_DAT,
    input  r_dir, r_bomb, b_dir, b_bomb, rx_valid, rx_byte, frame_err
  );

  // Controller side
  modport slave (
    input  PS2_CLK, PS2_DAT,
    output r_dir, r_bomb, b_dir, b_bomb, rx_valid, rx_byte, frame_err
  );
endinterface

// File: rtl/ps2_player_input_ctrl_rx_frame.sv
// PS/2 frame receiver: synchronise pins, sample data on falling clock edges, check parity/stop.
// Latency: rx_valid/frame_err one cycle after the synced stop-bit falling edge is seen.
// Backpressure: none; bytes are strobed out and must be consumed the same cycle.
// Optional mid-frame watchdog built only when PS2_WATCHDOG_EN is defined.
module ps2_rx_frame
  import ps2_input_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte,
  output logic       o_frame_err
);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  rx_state_t              r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_parity;

  logic w_clk_s;
  logic w_dat_s;
  logic w_fall;
  logic w_timeout;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

  // Synchronisers reset to the bus idle level so reset release never fakes an edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
      r_clk_prev <= w_clk_s;
    end
  end

`ifdef PS2_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;

  assign w_timeout = (r_state != RX_IDLE) && !w_fall &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Count idle cycles since the last falling edge while a frame is in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == RX_IDLE || w_fall || w_timeout) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Bit-level frame FSM; a start bit of 1 is treated as noise and ignored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= RX_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      o_rx_valid  <= 1'b0;
      o_rx_byte   <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      if (w_timeout) begin
        r_state     <= RX_IDLE;
        o_frame_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          RX_IDLE: begin
            if (!w_dat_s) begin
              r_state   <= RX_DATA;
              r_bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= RX_PARITY;
          end
          RX_PARITY: begin
            r_parity <= w_dat_s;
            r_state  <= RX_STOP;
          end
          RX_STOP: begin
            r_state <= RX_IDLE;
            if (w_dat_s && (^{r_shift, r_parity})) begin
              o_rx_valid <= 1'b1;
              o_rx_byte  <= r_shift;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_player_input_ctrl.sv
// PS/2 set-2 decoder driving per-player one-hot directions (last pressed wins) and bomb pulses.
// Latency: dir/bomb update the cycle after rx_valid.
// Backpressure: none; one key event per received byte, consumed immediately.
// PS2_WATCHDOG_EN enables the receiver's mid-frame timeout.
module ps2_player_input_ctrl
  import ps2_input_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                     CLOCK_50,
  input logic                     resetn,
  ps2_player_input_ctrl_if.slave  bus
);

  logic       w_rx_valid;
  logic [7:0] w_rx_byte;
  logic       w_frame_err;

  ps2_rx_frame #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .i_clk       (CLOCK_50),
    .i_rst_n     (resetn),
    .i_ps2_clk   (bus.PS2_CLK),
    .i_ps2_dat   (bus.PS2_DAT),
    .o_rx_valid  (w_rx_valid),
    .o_rx_byte   (w_rx_byte),
    .o_frame_err (w_frame_err)
  );

  dec_state_t r_dec;
  logic       w_is_ext;
  logic       w_is_brk;
  logic       w_evt_vld;
  logic       w_evt_make;
  logic       w_evt_ext;

  assign w_is_ext = (w_rx_byte == PFX_EXT);
  assign w_is_brk = (w_rx_byte == PFX_BRK);

  // Turn the current byte plus prefix state into a make/break key event
  always_comb begin
    w_evt_vld  = 1'b0;
    w_evt_make = 1'b0;
    w_evt_ext  = 1'b0;
    if (w_rx_valid) begin
      case (r_dec)
        DEC_BASE: begin
          if (!w_is_ext && !w_is_brk) begin
            w_evt_vld  = 1'b1;
            w_evt_make = 1'b1;
          end
        end
        DEC_EXT: begin
          if (!w_is_brk) begin
            w_evt_vld  = 1'b1;
            w_evt_make = 1'b1;
            w_evt_ext  = 1'b1;
          end
        end
        DEC_BRK: w_evt_vld = 1'b1;
        DEC_EXT_BRK: begin
          w_evt_vld = 1'b1;
          w_evt_ext = 1'b1;
        end
        default: w_evt_vld = 1'b0;
      endcase
    end
  end

  // Prefix tracker; a rejected frame abandons any partial E0/F0 sequence
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_dec <= DEC_BASE;
    end else if (w_frame_err) begin
      r_dec <= DEC_BASE;
    end else if (w_rx_valid) begin
      case (r_dec)
        DEC_BASE: begin
          if (w_is_ext)      r_dec <= DEC_EXT;
          else if (w_is_brk) r_dec <= DEC_BRK;
        end
        DEC_EXT: r_dec <= w_is_brk ? DEC_EXT_BRK : DEC_BASE;
        default: r_dec <= DEC_BASE;
      endcase
    end
  end

  logic [1:0][3:0] w_dir;
  logic [1:0]      w_bomb;

  for (genvar p = 0; p < 2; p++) begin : g_player
    key_hit_t         w_key;
    logic [3:0]       w_key_oh;
    logic [NKEYS-1:0] r_held;
    logic [3:0]       r_cur;
    logic             r_bomb_q;

    assign w_key    = key_lookup((p == 1), w_rx_byte, w_evt_ext);
    assign w_key_oh = 4'b0001 << w_key.idx[1:0];

    // Held-key tracking, last-pressed direction arbitration and bomb edge detect
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        r_held   <= '0;
        r_cur    <= '0;
        r_bomb_q <= 1'b0;
      end else begin
        r_bomb_q <= 1'b0;
        if (w_evt_vld && w_key.hit) begin
          if (w_evt_make) begin
            r_held[w_key.idx] <= 1'b1;
            if (w_key.idx == 3'(BOMB)) r_bomb_q <= ~r_held[BOMB];
            else                        r_cur    <= w_key_oh;
          end else begin
            r_held[w_key.idx] <= 1'b0;
            if (w_key.idx != 3'(BOMB) && r_cur == w_key_oh)
              r_cur <= first_held(r_held[3:0] & ~w_key_oh);
          end
        end
      end
    end

    assign w_dir[p]  = r_cur;
    assign w_bomb[p] = r_bomb_q;
  end

  assign bus.r_dir     = w_dir[0];
  assign bus.r_bomb    = w_bomb[0];
  assign bus.b_dir     = w_dir[1];
  assign bus.b_bomb    = w_bomb[1];
  assign bus.rx_valid  = w_rx_valid;
  assign bus.rx_byte   = w_rx_byte;
  assign bus.frame_err = w_frame_err;

endmodule
